ysyx_22050058_mem_arbiter: RTL

Two-requester arbiter that shares the single physical memory port between instruction fetch (IF) and the load/store unit (LS). It sits between the fetch stage / MEM stage and the memory interface and holds one transaction in flight at a time. It returns fetch words already split to 32 bits and raises per-requester stall requests toward CtrlBlock.

---
 rtl/ysyx_22050058_mem_arbiter_pkg.sv | 21 ++
 rtl/ysyx_22050058_mem_arbiter_if.sv | 25 ++
 rtl/ysyx_22050058_mem_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ysyx_22050058_mem_arbiter_pkg.sv
// Shared defines for the IF/LS memory arbiter: FSM encodings,
// owner tags, zero word and control polarities.
package ysyx_22050058_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } arb_owner_e;

    localparam logic [63:0] ZeroWord     = 64'h0;
    localparam logic        StallEnable  = 1'b1;
    localparam logic        StallDisable = 1'b0;
    localparam logic        FlushEnable  = 1'b1;

endpackage

// File: rtl/ysyx_22050058_mem_arbiter_if.sv
// Single physical memory port: request payload out, ready/response in.
// The arbiter drives it through the master modport.
interface ysyx_22050058_mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic                  mem_ready;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/ysyx_22050058_mem_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction
// in flight; LS has fixed priority, fetch words are split to 32 bits.
module ysyx_22050058_mem_arbiter
    import ysyx_22050058_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_valid,
    output logic [31:0]         if_inst,

    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_valid,
    output logic [DATA_W-1:0]   ls_rdata,

    ysyx_22050058_mem_arbiter_if.master mem,

    output logic                stall_if,
    output logic                stall_ls
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_e          state;
    arb_owner_e          owner;
    logic                drop;
    logic                req_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic                if_valid_q;
    logic                ls_valid_q;
    logic [31:0]         if_inst_q;
    logic [DATA_W-1:0]   ls_rdata_q;
    logic                flush_on;
    logic                if_busy;

    assign flush_on = (if_flush == FlushEnable);
    assign if_busy  = (owner == OWNER_IF);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWNER_IF;
            drop       <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            if_valid_q <= 1'b0;
            ls_valid_q <= 1'b0;
            if_inst_q  <= ZeroWord[31:0];
            ls_rdata_q <= '0;
        end else begin
            if_valid_q <= 1'b0;
            ls_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (ls_req) begin
                        owner   <= OWNER_LS;
                        addr_q  <= ls_addr;
                        we_q    <= ls_we;
                        wdata_q <= ls_wdata;
                        wmask_q <= ls_we ? ls_wmask : '0;
                        req_q   <= 1'b1;
                        state   <= ISSUE;
                    end else if (if_req && !flush_on) begin
                        owner   <= OWNER_IF;
                        addr_q  <= if_addr;
                        we_q    <= 1'b0;
                        wdata_q <= '0;
                        wmask_q <= '0;
                        req_q   <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (if_busy && flush_on) drop <= 1'b1;
                    if (mem.mem_ready) begin
                        req_q <= 1'b0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (if_busy && flush_on) drop <= 1'b1;
                    if (mem.mem_rvalid) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                        if (!if_busy) begin
                            ls_valid_q <= 1'b1;
                            if (!we_q) ls_rdata_q <= mem.mem_rdata;
                        end else if (!(drop || flush_on)) begin
                            // a flushed fetch still completes on the bus
                            if_valid_q <= 1'b1;
                            if_inst_q  <= addr_q[2] ? mem.mem_rdata[63:32]
                                                    : mem.mem_rdata[31:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wmask = wmask_q;

    assign if_valid = if_valid_q;
    assign if_inst  = if_inst_q;
    assign ls_valid = ls_valid_q;
    assign ls_rdata = ls_rdata_q;

    assign stall_if = (if_req && !if_valid_q) ? StallEnable : StallDisable;
    assign stall_ls = (ls_req && !ls_valid_q) ? StallEnable : StallDisable;

endmodule
